// File: rtl/musicbox_sequencer.sv
// musicbox_sequencer: speaker sequencer with four modes (silent, 440 Hz tone,
// 440/880 Hz siren, looping note pattern). The pattern comes from a 16x4 table
// that can be written at run time.
module musicbox_sequencer #(
    parameter int CLK_HZ      = 50000000,
    parameter int STEP_HZ     = 4,
    parameter int SEQ_LEN     = 16,
    parameter int SIREN_STEPS = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [1:0] MODE,
    input  logic       WR_EN,
    input  logic [3:0] WR_ADDR,
    input  logic [3:0] WR_DATA,
    output logic       SPEAKER,
    output logic       LED,
    output logic [3:0] STEP_IDX,
    output logic [3:0] NOTE_CODE
);

    localparam int STEP_DIV = CLK_HZ / STEP_HZ;
    // 440 Hz has the longest half period, so it sizes the tone counter
    localparam int TW = $clog2(CLK_HZ / 880 + 1);
    localparam int SW = $clog2(STEP_DIV + 1);
    localparam logic [SW-1:0] STEP_RLD = SW'(STEP_DIV - 1);
    localparam logic [3:0] NOTE_LO = 4'd1;
    localparam logic [3:0] NOTE_HI = 4'd13;

    typedef enum logic [1:0] {
        M_SILENT  = 2'b00,
        M_TONE    = 2'b01,
        M_SIREN   = 2'b10,
        M_PATTERN = 2'b11
    } mode_t;

    // Half period minus one for a note code; rests park the counter at the
    // 440 Hz reload value, which is never used while the rest lasts.
    function automatic logic [TW-1:0] hp_m1(input logic [3:0] code);
        int f;
        case (code)
            4'd1:    f = 440;
            4'd2:    f = 466;
            4'd3:    f = 494;
            4'd4:    f = 523;
            4'd5:    f = 554;
            4'd6:    f = 587;
            4'd7:    f = 622;
            4'd8:    f = 659;
            4'd9:    f = 698;
            4'd10:   f = 740;
            4'd11:   f = 784;
            4'd12:   f = 831;
            4'd13:   f = 880;
            default: f = 440;
        endcase
        return TW'(CLK_HZ / (2 * f) - 1);
    endfunction

    function automatic logic is_rest(input logic [3:0] code);
        return (code == 4'd0) || (code >= 4'd14);
    endfunction

    mode_t           mode_q, mode_d, mode_in;
    logic [3:0]      idx_q, idx_d, note_q, note_d;
    logic [3:0]      nidx, nxt_note, first_note;
    logic            spk_q, spk_d, led_q, led_d, phase_q, phase_d, phase_n, tick;
    logic [7:0]      scnt_q, scnt_d;
    logic [SW-1:0]   step_q, step_d;
    logic [TW-1:0]   tone_q, tone_d;
    logic [15:0][3:0] tbl_q, tbl_d;

    assign mode_in = mode_t'(MODE);

    // State register: everything clears asynchronously to its reset value
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q  <= M_TONE;
            idx_q   <= 4'd0;
            note_q  <= NOTE_LO;
            spk_q   <= 1'b0;
            led_q   <= 1'b0;
            phase_q <= 1'b0;
            scnt_q  <= 8'd0;
            step_q  <= STEP_RLD;
            tone_q  <= hp_m1(NOTE_LO);
            tbl_q   <= {16{4'd1}};
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            spk_q   <= spk_d;
            led_q   <= led_d;
            phase_q <= phase_d;
            scnt_q  <= scnt_d;
            step_q  <= step_d;
            tone_q  <= tone_d;
            tbl_q   <= tbl_d;
        end
    end

    // Next state: table write, then mode change / silent hold / normal stepping
    always_comb begin
        mode_d     = mode_q;
        idx_d      = idx_q;
        note_d     = note_q;
        spk_d      = spk_q;
        led_d      = led_q;
        phase_d    = phase_q;
        scnt_d     = scnt_q;
        step_d     = step_q;
        tone_d     = tone_q;
        tbl_d      = tbl_q;
        nidx       = idx_q;
        nxt_note   = note_q;
        first_note = NOTE_LO;
        phase_n    = phase_q;
        tick       = 1'b0;

        // Out-of-range addresses are dropped; fetches below read tbl_q, so a
        // same-edge write/fetch returns the old entry.
        if (WR_EN && (int'(WR_ADDR) < SEQ_LEN))
            tbl_d[WR_ADDR] = WR_DATA;

        if (mode_in != mode_q) begin
            case (mode_in)
                M_SILENT:  first_note = 4'd0;
                M_PATTERN: first_note = tbl_q[0];
                default:   first_note = NOTE_LO;
            endcase
            mode_d  = mode_in;
            idx_d   = 4'd0;
            phase_d = 1'b0;
            scnt_d  = 8'd0;
            step_d  = STEP_RLD;
            spk_d   = 1'b0;
            led_d   = 1'b0;
            note_d  = first_note;
            tone_d  = hp_m1(first_note);
        end else if (mode_q == M_SILENT) begin
            spk_d  = 1'b0;
            led_d  = 1'b0;
            note_d = 4'd0;
            idx_d  = 4'd0;
            step_d = STEP_RLD;
            tone_d = hp_m1(4'd0);
        end else begin
            tick   = (step_q == '0);
            step_d = tick ? STEP_RLD : step_q - SW'(1);
            if (tick) begin
                led_d = ~led_q;
                case (mode_q)
                    M_PATTERN: begin
                        nidx     = (idx_q == 4'(SEQ_LEN - 1)) ? 4'd0 : idx_q + 4'd1;
                        idx_d    = nidx;
                        nxt_note = tbl_q[nidx];
                    end
                    M_SIREN: begin
                        if (scnt_q == 8'(SIREN_STEPS - 1)) begin
                            scnt_d  = 8'd0;
                            phase_n = ~phase_q;
                        end else begin
                            scnt_d = scnt_q + 8'd1;
                        end
                        phase_d  = phase_n;
                        nxt_note = phase_n ? NOTE_HI : NOTE_LO;
                    end
                    default: nxt_note = NOTE_LO;
                endcase
            end
            note_d = nxt_note;

            // Tone generator: a note change reloads for the new pitch but
            // keeps the level; a coincident zero still inverts.
            if (is_rest(nxt_note)) begin
                spk_d  = 1'b0;
                tone_d = hp_m1(nxt_note);
            end else if (nxt_note != note_q) begin
                tone_d = hp_m1(nxt_note);
                if (tone_q == '0)
                    spk_d = ~spk_q;
            end else if (tone_q == '0) begin
                tone_d = hp_m1(note_q);
                spk_d  = ~spk_q;
            end else begin
                tone_d = tone_q - TW'(1);
            end
        end
    end

    assign SPEAKER   = spk_q;
    assign LED       = led_q;
    assign STEP_IDX  = idx_q;
    assign NOTE_CODE = note_q;

endmodule
